dm_arbiter: RTL
===============

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
- REQ-001 Parameters: none; mode encoding fixed: 2'b00 word, 2'b01 half, 2'b10 byte, 2'b11 illegal.
- REQ-002 clk  input  1  system clock; all state changes on posedge clk.
- REQ-003 reset  input  1  synchronous, active-high reset.
- REQ-004 rq0_valid, rq1_valid  input  1 each  requester n has a pending access.
- REQ-005 rqn_we  input  1  1 = store, 0 = load.
- REQ-006 rqn_mode  input  2  access width per REQ-001.
- REQ-007 rqn_addr  input  32  byte address.
- REQ-008 rqn_wdata  input  32  store data, low-aligned (half in [15:0], byte in [7:0]).
- REQ-009 rqn_ready  output  1  one-cycle accept pulse for requester n.
- REQ-010 rspn_valid  output  1  one-cycle response pulse for requester n.
- REQ-011 rsp_rdata  output  32  load data (memory-extended), shared by both responses.
- REQ-012 rsp_err  output  1  qualifies rspn_valid; 1 = misaligned or illegal access.
- REQ-013 dm_we  output  1  memory write enable.
- REQ-014 dm_mode  output  2  memory access mode.
- REQ-015 dm_addr  output  32  memory byte address.
- REQ-016 dm_wdata  output  32  memory write data.
- REQ-017 dm_rdata  input  32  combinational memory read data for current dm_addr/dm_mode.

Function
- REQ-018 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on any accept; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
- REQ-019 Accept happens only in IDLE: if exactly one rqn_valid, grant n; if both, grant the requester named by the round-robin pointer rr.
- REQ-020 On accept, assert rqn_ready for the granted requester in that cycle only and latch we, mode, addr, wdata, and the grant index.
- REQ-021 rr initialises to 0 and updates only on a contended accept (both valid), to the non-granted index; uncontended accepts do not change rr.
- REQ-022 A request is erroneous if mode == 2'b11, word with addr[1:0] != 0, or half with addr[0] != 0.
- REQ-023 In ACCESS, drive dm_addr/dm_mode/dm_wdata from the latch; dm_we = latched we AND NOT erroneous, high for exactly that one cycle.
- REQ-024 In ACCESS, capture dm_rdata into rsp_rdata register for non-erroneous loads; for stores and erroneous requests capture 32'h0.
- REQ-025 In RESP, assert rspn_valid for the latched grant only, with rsp_err per REQ-022; rsp_rdata holds its value until next capture.
- REQ-026 Latency: accept at cycle T, memory write/read at T+1, response at T+2; maximum throughput one access per 3 cycles.
- REQ-027 Outside ACCESS: dm_we = 0; dm_addr, dm_mode, dm_wdata hold last latched values.
- REQ-028 Requests arriving in ACCESS/RESP are not accepted; requesters hold rqn_valid and fields stable until rqn_ready.
- REQ-029 rqn_ready and rspn_valid never both high for different requesters in one cycle; at most one rqn_ready high per cycle.

Reset
- REQ-030 With reset high at posedge: state = IDLE, rr = 0, all ready/valid/err/dm_we = 0, rsp_rdata = 0, latch and dm_addr/dm_mode/dm_wdata = 0.
- REQ-031 Reset in ACCESS aborts the access: dm_we low from the next cycle, no response issued.

Verification
- REQ-032 rq0 store word addr 0x10 data 0xDEADBEEF, then rq1 load word 0x10 -> rq1 response at T+2 with rsp_rdata 0xDEADBEEF, rsp_err 0.
- REQ-033 Both valid continuously from reset -> grants alternate 0,1,0,1 every 3 cycles.
- REQ-034 rq0 store half addr 0x11 -> dm_we never asserted, rsp0_valid with rsp_err 1, memory unchanged.
- REQ-035 rq1 load byte at address holding 0x80 -> rsp_rdata 0xFFFFFF80, rsp_err 0.
- REQ-036 Reset asserted in ACCESS of a store -> no response, dm_we 0 after reset, rr = 0.
- REQ-037 rq0 mode 2'b11 load -> rsp_err 1, rsp_rdata 0.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-requester data-memory arbiter: round-robin on contention, one access per
// three cycles (accept, memory access, response), with misalignment/illegal-mode checking.
module dm_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        rq0_valid,
    input  logic        rq0_we,
    input  logic [1:0]  rq0_mode,
    input  logic [31:0] rq0_addr,
    input  logic [31:0] rq0_wdata,
    input  logic        rq1_valid,
    input  logic        rq1_we,
    input  logic [1:0]  rq1_mode,
    input  logic [31:0] rq1_addr,
    input  logic [31:0] rq1_wdata,
    output logic        rq0_ready,
    output logic        rq1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        dm_we,
    output logic [1:0]  dm_mode,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic        grant_q, grant_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        contended;
    logic        sel;
    logic        sel_we;
    logic        sel_err;
    logic [1:0]  sel_mode;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    // Accept is gated by reset so no ready pulse is seen for a request that is not latched.
    always_comb begin
        contended = rq0_valid && rq1_valid;
        accept    = (state_q == IDLE) && !reset && (rq0_valid || rq1_valid);
        sel       = contended ? rr_q : rq1_valid;
        sel_we    = sel ? rq1_we    : rq0_we;
        sel_mode  = sel ? rq1_mode  : rq0_mode;
        sel_addr  = sel ? rq1_addr  : rq0_addr;
        sel_wdata = sel ? rq1_wdata : rq0_wdata;
        sel_err   = (sel_mode == 2'b11)
                 || ((sel_mode == 2'b00) && (sel_addr[1:0] != 2'b00))
                 || ((sel_mode == 2'b01) && sel_addr[0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q    <= 1'b0;
            grant_q <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            rr_q    <= rr_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            err_q   <= err_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // The pointer only moves on contention, handing priority to the loser.
    always_comb begin
        rr_d    = rr_q;
        grant_d = grant_q;
        we_d    = we_q;
        err_d   = err_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (accept) begin
            grant_d = sel;
            we_d    = sel_we;
            err_d   = sel_err;
            mode_d  = sel_mode;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            if (contended) rr_d = ~sel;
        end
        if (state_q == ACCESS) begin
            rdata_d = (we_q || err_q) ? 32'h0 : dm_rdata;
        end
    end

    always_comb begin
        rq0_ready  = accept && !sel;
        rq1_ready  = accept && sel;
        rsp0_valid = (state_q == RESP) && !grant_q;
        rsp1_valid = (state_q == RESP) && grant_q;
        rsp_err    = (state_q == RESP) && err_q;
        dm_we      = (state_q == ACCESS) && we_q && !err_q;
        dm_mode    = mode_q;
        dm_addr    = addr_q;
        dm_wdata   = wdata_q;
        rsp_rdata  = rdata_q;
    end

endmodule
